// File: rtl/matrix_transpose_seq_pkg.sv
// -----------------------------------------------------------------------------
// matrix_transpose_seq_pkg
// Shared definitions for the sequential matrix transposer:
//   FLOAT_W   - width of one matrix element (raw float32 word)
//   state_t   - controller state encoding
//   idx_width - address width helper that stays >= 1 for single-entry arrays
// Flat-bus convention: word w of a matrix bus lives at [w*FLOAT_W +: FLOAT_W].
// -----------------------------------------------------------------------------
package matrix_transpose_seq_pkg;

  localparam int FLOAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_transpose_seq_index_gen.sv
// -----------------------------------------------------------------------------
// matrix_transpose_seq_index_gen
// Transpose index generator. Holds a base position (i, j, k, dst) and derives
// LANES consecutive positions from it with a chain of wrapping incrementers,
// so no divider or modulo is needed:
//   j wraps at C-1 and then i increments; k = i*C+j; dst = j*R+i.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   i_clear      - restart at element (0,0)
//   i_advance    - step the base position by LANES elements
//   i_rows       - R, i_cols - C, i_count - P = R*C
//   o_src_idx    - per-lane source word index k
//   o_dst_idx    - per-lane destination word index j*R+i
//   o_valid      - per-lane k < P
//   o_last       - the current group of lanes reaches the final element
// -----------------------------------------------------------------------------
module matrix_transpose_seq_index_gen #(
  parameter int LANES = 1,
  parameter int IDX_W = 8,
  parameter int AW    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_advance,
  input  logic [IDX_W-1:0]           i_rows,
  input  logic [IDX_W-1:0]           i_cols,
  input  logic [IDX_W-1:0]           i_count,
  output logic [LANES-1:0][AW-1:0]   o_src_idx,
  output logic [LANES-1:0][AW-1:0]   o_dst_idx,
  output logic [LANES-1:0]           o_valid,
  output logic                       o_last
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic [IDX_W-1:0] r_i, r_j, r_k, r_dst;

  // Element 0 of each chain is the registered base; element LANES is the
  // base for the next advance.
  logic [IDX_W-1:0] w_i   [LANES+1];
  logic [IDX_W-1:0] w_j   [LANES+1];
  logic [IDX_W-1:0] w_k   [LANES+1];
  logic [IDX_W-1:0] w_dst [LANES+1];
  logic [LANES-1:0] w_wrap;

  assign w_i[0]   = r_i;
  assign w_j[0]   = r_j;
  assign w_k[0]   = r_k;
  assign w_dst[0] = r_dst;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_wrap[gi]    = (w_j[gi] == i_cols - ONE);
      assign w_j[gi+1]     = w_wrap[gi] ? '0 : w_j[gi] + ONE;
      assign w_i[gi+1]     = w_wrap[gi] ? w_i[gi] + ONE : w_i[gi];
      // Moving to (i+1, 0) lands on destination word i+1; otherwise one
      // column step in the source is one R-sized row step in the result.
      assign w_dst[gi+1]   = w_wrap[gi] ? w_i[gi] + ONE : w_dst[gi] + i_rows;
      assign w_k[gi+1]     = w_k[gi] + ONE;
      assign o_valid[gi]   = (w_k[gi] < i_count);
      assign o_src_idx[gi] = w_k[gi][AW-1:0];
      assign o_dst_idx[gi] = w_dst[gi][AW-1:0];
    end
  endgenerate

  assign o_last = (w_k[LANES] >= i_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_dst <= '0;
    end else if (i_clear) begin
      r_i   <= '0;
      r_j   <= '0;
      r_k   <= '0;
      r_dst <= '0;
    end else if (i_advance) begin
      r_i   <= w_i[LANES];
      r_j   <= w_j[LANES];
      r_k   <= w_k[LANES];
      r_dst <= w_dst[LANES];
    end
  end

endmodule

// File: rtl/matrix_transpose_seq.sv
// -----------------------------------------------------------------------------
// matrix_transpose_seq
// Sequential, runtime-sized transposer for flat float32 matrices (raw word
// moves only). Produces the B_T operand for the matrix multipliers.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   start     - request a transpose (accepted in IDLE or DONE)
//   rows/cols - runtime R x C of in_mat, latched on accepted start
//   in_mat    - row-major input, element (i,j) at word i*C+j
//   out_mat   - transposed result, element (j,i) at word j*R+i
//   busy      - copy in progress
//   done      - level, high from completion until next accepted start
//   err       - level, high with done when the dimensions were illegal
// -----------------------------------------------------------------------------
module matrix_transpose_seq
  import matrix_transpose_seq_pkg::*;
#(
  parameter int MAX_ROWS  = 4,
  parameter int MAX_COLS  = 4,
  parameter int MOD_COUNT = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [31:0]                            rows,
  input  logic [31:0]                            cols,
  input  logic [FLOAT_W*MAX_ROWS*MAX_COLS-1:0]   in_mat,
  output logic [FLOAT_W*MAX_ROWS*MAX_COLS-1:0]   out_mat,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   err
);

  localparam int N     = MAX_ROWS * MAX_COLS;
  localparam int AW    = idx_width(N);
  // Headroom so lane counters running past P (masked lanes) cannot alias.
  localparam int IDX_W = idx_width((N + MOD_COUNT) * (MAX_ROWS + 1)) + 1;

  state_t r_state, w_state_next;

  logic [FLOAT_W-1:0] r_in  [N];
  logic [FLOAT_W-1:0] r_out [N];
  logic [IDX_W-1:0]   r_rows, r_cols, r_count;
  logic               r_err;

  logic                         w_accept, w_legal, w_last;
  logic [MOD_COUNT-1:0][AW-1:0] w_src_idx, w_dst_idx;
  logic [MOD_COUNT-1:0]         w_valid;

  matrix_transpose_seq_index_gen #(
    .LANES (MOD_COUNT),
    .IDX_W (IDX_W),
    .AW    (AW)
  ) u_index_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_advance (r_state == ST_RUN),
    .i_rows    (r_rows),
    .i_cols    (r_cols),
    .i_count   (r_count),
    .o_src_idx (w_src_idx),
    .o_dst_idx (w_dst_idx),
    .o_valid   (w_valid),
    .o_last    (w_last)
  );

  always_comb begin
    w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    w_legal  = (rows != 32'd0) && (cols != 32'd0) &&
               (rows <= 32'(MAX_ROWS)) && (cols <= 32'(MAX_COLS));
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = w_legal ? ST_RUN : ST_ERR;
    end else begin
      case (r_state)
        ST_RUN:  if (w_last) w_state_next = ST_DONE;
        ST_ERR:  w_state_next = ST_DONE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rows  <= '0;
      r_cols  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int w = 0; w < N; w++) begin
        r_in[w]  <= '0;
        r_out[w] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        // Only legal dimensions are ever used, so the narrowed copies suffice.
        r_rows  <= rows[IDX_W-1:0];
        r_cols  <= cols[IDX_W-1:0];
        r_count <= rows[IDX_W-1:0] * cols[IDX_W-1:0];
        r_err   <= 1'b0;
        for (int w = 0; w < N; w++) begin
          r_in[w]  <= in_mat[w*FLOAT_W +: FLOAT_W];
          r_out[w] <= '0;
        end
      end else if (r_state == ST_RUN) begin
        for (int l = 0; l < MOD_COUNT; l++) begin
          if (w_valid[l]) r_out[w_dst_idx[l]] <= r_in[w_src_idx[l]];
        end
      end else if (r_state == ST_ERR) begin
        r_err <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_out
      assign out_mat[gi*FLOAT_W +: FLOAT_W] = r_out[gi];
    end
  endgenerate

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign err  = r_err;

endmodule

// File: tb/tb_matrix_transpose_seq.sv
// -----------------------------------------------------------------------------
// tb_matrix_transpose_seq
// Directed bench for matrix_transpose_seq: one instance with one copy lane
// per cycle and one with two lanes, sharing clock, reset and data inputs.
// -----------------------------------------------------------------------------
module tb_matrix_transpose_seq;

  typedef logic [31:0] vec_t [16];

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start1 = 1'b0, start2 = 1'b0;
  logic [31:0]  rows = '0, cols = '0;
  logic [511:0] in_mat = '0;
  logic [511:0] out1, out2;
  logic         busy1, done1, err1, busy2, done2, err2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  matrix_transpose_seq #(.MAX_ROWS(4), .MAX_COLS(4), .MOD_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .rows(rows), .cols(cols),
    .in_mat(in_mat), .out_mat(out1), .busy(busy1), .done(done1), .err(err1)
  );

  matrix_transpose_seq #(.MAX_ROWS(4), .MAX_COLS(4), .MOD_COUNT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .rows(rows), .cols(cols),
    .in_mat(in_mat), .out_mat(out2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] get_out(input int sel);
    return (sel == 1) ? out1 : out2;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? busy1 : busy2;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 1) ? done1 : done2;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 1) ? err1 : err2;
  endfunction

  // Drive a request at the falling edge; returns #1 after the start edge.
  task automatic launch(input int sel, input logic [31:0] r, input logic [31:0] c,
                        input vec_t w, input bit hold);
    @(negedge clk);
    rows = r;
    cols = c;
    for (int i = 0; i < 16; i++) in_mat[i*32 +: 32] = w[i];
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start1 = 1'b0;
      start2 = 1'b0;
    end
  endtask

  // Counts edges after the start edge until done, plus busy-high samples.
  task automatic wait_done(input int sel, input string tag, input int exp_lat,
                           input bit exp_err, input bit hold);
    int n = 0;
    int bcnt = 0;
    check({tag, " done_low_after_start"}, 32'(get_done(sel)), 32'd0);
    if (get_busy(sel)) bcnt++;
    while (!get_done(sel) && n < 200) begin
      if (hold && n == 0) in_mat = {16{32'hDEAD_BEEF}};
      @(posedge clk);
      #1;
      n++;
      if (get_busy(sel)) bcnt++;
    end
    if (hold) start1 = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(bcnt), exp_err ? 32'd0 : 32'(exp_lat));
    check({tag, " err"}, 32'(get_err(sel)), 32'(exp_err));
  endtask

  task automatic check_out(input int sel, input string tag, input vec_t exp);
    logic [511:0] o;
    o = get_out(sel);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s out[%0d]", tag, i), o[i*32 +: 32], exp[i]);
    $display("transaction %s: dut%0d compared", tag, sel);
  endtask

  localparam vec_t ZERO   = '{default: 32'd0};
  localparam vec_t SEQ6   = '{1,2,3,4,5,6,0,0,0,0,0,0,0,0,0,0};
  localparam vec_t SEQ4   = '{1,2,3,4,0,0,0,0,0,0,0,0,0,0,0,0};
  localparam vec_t SEQ9   = '{1,2,3,4,5,6,7,8,9,0,0,0,0,0,0,0};
  localparam vec_t SEQ16  = '{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16};
  localparam vec_t ROW4   = '{7,8,9,10,0,0,0,0,0,0,0,0,0,0,0,0};
  localparam vec_t T3X2   = '{1,3,5,2,4,6,0,0,0,0,0,0,0,0,0,0};
  localparam vec_t T2X2   = '{1,3,2,4,0,0,0,0,0,0,0,0,0,0,0,0};
  localparam vec_t T3X3   = '{1,4,7,2,5,8,3,6,9,0,0,0,0,0,0,0};
  localparam vec_t T4X4   = '{1,5,9,13,2,6,10,14,3,7,11,15,4,8,12,16};
  localparam vec_t T2X3   = '{1,4,2,5,3,6,0,0,0,0,0,0,0,0,0,0};

  initial begin
    // Reset state
    #2;
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset done1", 32'(done1), 32'd0);
    check("reset err1",  32'(err1),  32'd0);
    check("reset busy2", 32'(busy2), 32'd0);
    check_out(1, "reset", ZERO);
    @(negedge clk);
    rst = 1'b0;

    // 3x2, one lane per cycle
    launch(1, 3, 2, SEQ6, 1'b0);
    wait_done(1, "3x2", 6, 1'b0, 1'b0);
    check_out(1, "3x2", T3X2);

    // 2x2, two lanes per cycle
    launch(2, 2, 2, SEQ4, 1'b0);
    wait_done(2, "2x2 m2", 2, 1'b0, 1'b0);
    check_out(2, "2x2 m2", T2X2);

    // 3x3 with odd element count on the two-lane instance
    launch(2, 3, 3, SEQ9, 1'b0);
    wait_done(2, "3x3 m2", 5, 1'b0, 1'b0);
    check_out(2, "3x3 m2", T3X3);

    // Full-size 4x4 on the two-lane instance
    launch(2, 4, 4, SEQ16, 1'b0);
    wait_done(2, "4x4 m2", 8, 1'b0, 1'b0);
    check_out(2, "4x4 m2", T4X4);

    // Row vector then column vector (start accepted in DONE)
    launch(1, 1, 4, ROW4, 1'b0);
    wait_done(1, "1x4", 4, 1'b0, 1'b0);
    check_out(1, "1x4", ROW4);
    launch(1, 4, 1, ROW4, 1'b0);
    wait_done(1, "4x1", 4, 1'b0, 1'b0);
    check_out(1, "4x1", ROW4);

    // Illegal dimensions
    launch(1, 0, 3, SEQ6, 1'b0);
    wait_done(1, "rows0", 1, 1'b1, 1'b0);
    check_out(1, "rows0", ZERO);
    launch(1, 5, 2, SEQ6, 1'b0);
    wait_done(1, "rows5", 1, 1'b1, 1'b0);
    launch(1, 1, 32'h8000_0001, SEQ6, 1'b0);
    wait_done(1, "cols_huge", 1, 1'b1, 1'b0);
    check_out(1, "cols_huge", ZERO);

    // Reset during RUN aborts immediately
    launch(1, 3, 3, SEQ9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort partial out[0]", out1[31:0], 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy1), 32'd0);
    check("abort done", 32'(done1), 32'd0);
    check("abort out[0]", out1[31:0], 32'd0);
    check("abort out[3]", out1[127:96], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    launch(1, 3, 3, SEQ9, 1'b0);
    wait_done(1, "3x3 restart", 9, 1'b0, 1'b0);
    check_out(1, "3x3 restart", T3X3);

    // start held through RUN, live data scrambled during RUN
    launch(1, 3, 2, SEQ6, 1'b1);
    wait_done(1, "3x2 held", 6, 1'b0, 1'b1);
    check_out(1, "3x2 held", T3X2);

    // New start while in DONE
    launch(1, 2, 3, SEQ6, 1'b0);
    wait_done(1, "2x3", 6, 1'b0, 1'b0);
    check_out(1, "2x3", T2X3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
